// File: rtl/memory_arbiter_if.sv
// Line-wide memory port shared by the caches, the arbiter and main memory.
// The master drives the request; the slave answers with ready and read data.
interface memory_interface #(
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned LINE_SIZE = 256
);
    logic [ADDR_SIZE-1:0] addr;
    logic [LINE_SIZE-1:0] wr_data;
    logic [LINE_SIZE-1:0] rd_data;
    logic                 write;
    logic                 valid;
    logic                 ready;

    modport master (
        output addr, wr_data, write, valid,
        input  rd_data, ready
    );

    modport slave (
        input  addr, wr_data, write, valid,
        output rd_data, ready
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter letting the I-cache and D-cache share one memory port.
// One transaction is outstanding at a time; the loser only ever sees ready = 1.
module memory_arbiter #(
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned LINE_SIZE = 256
) (
    input logic            clk_i,
    input logic            reset_i,
    memory_interface.slave  icache_bus,
    memory_interface.slave  dcache_bus,
    memory_interface.master memory_bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    state_e state_q, state_d;
    grant_e grant_q, grant_d;
    grant_e last_grant_q, last_grant_d;

    grant_e               winner;
    logic                 any_valid;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [LINE_SIZE-1:0] sel_wr_data;
    logic                 sel_write;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            grant_q      <= GRANT_I;
            last_grant_q <= GRANT_I;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Winner on a tie is whichever requester was not served last.
    always_comb begin
        any_valid = icache_bus.valid | dcache_bus.valid;
        if (icache_bus.valid && dcache_bus.valid) begin
            winner = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (dcache_bus.valid) begin
            winner = GRANT_D;
        end else begin
            winner = GRANT_I;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (any_valid && memory_bus.ready) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (!memory_bus.ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (memory_bus.ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        if (grant_q == GRANT_D) begin
            sel_addr    = dcache_bus.addr;
            sel_wr_data = dcache_bus.wr_data;
            sel_write   = dcache_bus.write;
        end else begin
            sel_addr    = icache_bus.addr;
            sel_wr_data = icache_bus.wr_data;
            sel_write   = icache_bus.write;
        end
    end

    // Output logic
    always_comb begin
        icache_bus.ready   = 1'b1;
        dcache_bus.ready   = 1'b1;
        memory_bus.valid   = 1'b0;
        memory_bus.write   = 1'b0;
        memory_bus.addr    = '0;
        memory_bus.wr_data = '0;
        case (state_q)
            ISSUE: begin
                memory_bus.valid   = 1'b1;
                memory_bus.write   = sel_write;
                memory_bus.addr    = sel_addr;
                memory_bus.wr_data = sel_wr_data;
                if (grant_q == GRANT_D) begin
                    dcache_bus.ready = 1'b0;
                end else begin
                    icache_bus.ready = 1'b0;
                end
            end
            WAIT: begin
                memory_bus.write   = sel_write;
                memory_bus.addr    = sel_addr;
                memory_bus.wr_data = sel_wr_data;
                if (grant_q == GRANT_D) begin
                    dcache_bus.ready = memory_bus.ready;
                end else begin
                    icache_bus.ready = memory_bus.ready;
                end
            end
            default: begin
            end
        endcase
    end

    assign icache_bus.rd_data = memory_bus.rd_data;
    assign dcache_bus.rd_data = memory_bus.rd_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised bench for memory_arbiter: two cache requesters and a memory
// with random accept/latency timing, checked against a transaction-level model.
module tb_memory_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memory_interface #(.ADDR_SIZE(AW), .LINE_SIZE(LW)) ibus ();
    memory_interface #(.ADDR_SIZE(AW), .LINE_SIZE(LW)) dbus ();
    memory_interface #(.ADDR_SIZE(AW), .LINE_SIZE(LW)) mbus ();

    memory_arbiter #(.ADDR_SIZE(AW), .LINE_SIZE(LW)) dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .icache_bus (ibus),
        .dcache_bus (dbus),
        .memory_bus (mbus)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        logic [LW-1:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = a ^ (32'h9E37_79B9 * (i + 1));
        return l;
    endfunction

    // Requesters (index 0 = I-cache, 1 = D-cache)
    logic          req_valid [2];
    logic          req_write [2];
    logic [AW-1:0] req_addr  [2];
    logic [LW-1:0] req_data  [2];
    int            rphase    [2];   // 0 idle, 1 requesting, 2 accepted
    logic          rdy_s     [2];
    logic [LW-1:0] rd_s      [2];

    // Memory
    logic          mr;
    logic [LW-1:0] mrd;
    int            mphase, mhold, mlat;
    logic [AW-1:0] maddr;

    // Captured inputs of the current cycle
    logic iv_c, dv_c, mr_c, rst_c;

    // Reference model: who owns the memory port and whether memory took the request
    bit busy, acc;
    int owner, last;
    int pass [2];

    task automatic apply();
        ibus.valid   = req_valid[0];
        ibus.write   = req_write[0];
        ibus.addr    = req_addr[0];
        ibus.wr_data = req_data[0];
        dbus.valid   = req_valid[1];
        dbus.write   = req_write[1];
        dbus.addr    = req_addr[1];
        dbus.wr_data = req_data[1];
        mbus.ready   = mr;
        mbus.rd_data = mrd;
    endtask

    task automatic compare();
        logic          e_rdy [2];
        logic          e_mv, e_w;
        logic [AW-1:0] e_a;
        logic [LW-1:0] e_d;
        e_rdy[0] = 1'b1;
        e_rdy[1] = 1'b1;
        e_mv = 1'b0;
        e_w  = 1'b0;
        e_a  = '0;
        e_d  = '0;
        if (busy) begin
            e_mv = !acc;
            e_w  = req_write[owner];
            e_a  = req_addr[owner];
            e_d  = req_data[owner];
            e_rdy[owner] = acc ? mr : 1'b0;
        end
        check("i_ready", ibus.ready, e_rdy[0]);
        check("d_ready", dbus.ready, e_rdy[1]);
        check("m_valid", mbus.valid, e_mv);
        check("m_write", mbus.write, e_w);
        check("m_addr", mbus.addr, e_a);
        check("m_wr_data", mbus.wr_data, e_d);
        check("i_rd_data", ibus.rd_data, mrd);
        check("d_rd_data", dbus.rd_data, mrd);
    endtask

    task automatic model_step();
        int w;
        int other;
        logic ov;
        if (rst_c) begin
            busy = 0; acc = 0; owner = 0; last = 0;
            pass[0] = 0; pass[1] = 0;
        end else if (!busy) begin
            if ((iv_c || dv_c) && mr_c) begin
                if (iv_c && dv_c) w = 1 - last;
                else w = dv_c ? 1 : 0;
                other = 1 - w;
                ov = (other == 0) ? iv_c : dv_c;
                if (ov) pass[other]++;
                pass[w] = 0;
                check("fairness", pass[other] <= 1, 1'b1);
                busy = 1; acc = 0; owner = w; last = w;
            end
        end else if (!acc) begin
            if (!mr_c) acc = 1;
        end else if (mr_c) begin
            busy = 0;
        end
    endtask

    task automatic req_step(input int k);
        if (rst_c) begin
            rphase[k] = 0;
            req_valid[k] = 1'b0;
        end else if (rphase[k] == 1) begin
            if (!rdy_s[k]) rphase[k] = 2;
        end else if (rphase[k] == 2) begin
            if (rdy_s[k]) begin
                check(k == 1 ? "d_fill_data" : "i_fill_data", rd_s[k], line_of(req_addr[k]));
                rphase[k] = 0;
                req_valid[k] = 1'b0;
            end
        end
        if (rphase[k] == 0 && $urandom_range(0, 1) == 1) begin
            req_addr[k]  = $urandom();
            req_write[k] = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) req_data[k][i*32 +: 32] = $urandom();
            req_valid[k] = 1'b1;
            rphase[k] = 1;
        end
    endtask

    task automatic mem_step();
        logic [31:0] r;
        if (rst_c) mphase = 0;
        r = $urandom();
        mrd = {8{r}};
        if (mphase == 0) begin
            if (mbus.valid) begin
                mhold = $urandom_range(0, 3);
                mphase = 1;
            end else begin
                mr = ($urandom_range(0, 7) != 0);
            end
        end
        if (mphase == 1) begin
            if (mhold == 0) begin
                mr = 1'b0;
                maddr = mbus.addr;
                mlat = $urandom_range(0, 4);
                mphase = 2;
            end else begin
                mr = 1'b1;
                mhold--;
            end
        end else if (mphase == 2) begin
            if (mlat == 0) begin
                mr = 1'b1;
                mrd = line_of(maddr);
                mphase = 0;
            end else begin
                mr = 1'b0;
                mlat--;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_addr[k]  = '0;
            req_data[k]  = '0;
            rphase[k]    = 0;
            pass[k]      = 0;
        end
        mr = 1'b1;
        mrd = '0;
        maddr = '0;
        mphase = 0; mhold = 0; mlat = 0;
        busy = 0; acc = 0; owner = 0; last = 0;
        apply();
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            compare();
            iv_c = req_valid[0];
            dv_c = req_valid[1];
            mr_c = mr;
            rst_c = rst;
            rdy_s[0] = ibus.ready;
            rdy_s[1] = dbus.ready;
            rd_s[0] = ibus.rd_data;
            rd_s[1] = dbus.rd_data;
            @(posedge clk);
            #1;
            model_step();
            req_step(0);
            req_step(1);
            mem_step();
            if (mphase == 2) rst = ($urandom_range(0, 11) == 0);
            else rst = ($urandom_range(0, 99) == 0);
            apply();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester, round-robin arbiter that lets the instruction cache and the data cache share one line-wide `memory_interface` port to main memory. It sits between the two cache instances and the memory model/controller, and serialises their fill and writeback transactions. Each cache sees an ordinary memory port and needs no changes. One transaction is outstanding at a time.

## Interface
- `ADDR_SIZE`, default 32: byte address width on all three buses.
- `LINE_SIZE`, default 256 (32*8): data width of `wr_data`/`rd_data` in bits; one cache line.
- Ports:
- `clk_i`  input  1  clock; single clock domain, all state on posedge.
- `reset_i`  input  1  reset; synchronous, active-high.
- `icache_bus`  `memory_interface.slave`  bundle  I-cache requester. Fields: `addr` (ADDR_SIZE), `wr_data` (LINE_SIZE), `write` (1), `valid` (1) in; `rd_data` (LINE_SIZE), `ready` (1) out.
- `dcache_bus`  `memory_interface.slave`  bundle  D-cache requester; same fields as `icache_bus`.
- `memory_bus`  `memory_interface.master`  bundle  to memory. `addr`, `wr_data`, `write`, `valid` out; `rd_data`, `ready` in.

## Operation
- Requester protocol, per port: the requester raises `valid` and holds `valid`/`addr`/`write`/`wr_data` stable while its `ready` stays 1. `ready` falling means the request is accepted. `ready` rising again for one cycle means completion; `rd_data` is valid in that cycle.
- Registers: `state` in {IDLE, ISSUE, WAIT}, `grant` (0 = I, 1 = D) and `last_grant` (1 bit).
- IDLE:
  - Both `ready` outputs are 1. `memory_bus.valid`, `write`, `addr` and `wr_data` are 0.
  - If any requester `valid` and `memory_bus.ready` are both 1, latch `grant` and set `last_grant <= grant`, then go to ISSUE. Otherwise stay in IDLE.
- Winner selection:
  - Only one `valid`: that requester wins.
  - Both `valid`: the requester not equal to `last_grant` wins.
- ISSUE:
  - `memory_bus.valid = 1`. `addr`, `write` and `wr_data` are muxed combinationally from the granted bus.
  - Granted `ready = 0`. Non-granted `ready = 1`.
  - Go to WAIT when `memory_bus.ready == 0`. Otherwise stay in ISSUE with `valid` held.
- WAIT:
  - `memory_bus.valid = 0`. `addr`, `write` and `wr_data` are still muxed from the granted bus.
  - Granted `ready = memory_bus.ready`. Non-granted `ready = 1`.
  - Go to IDLE when `memory_bus.ready == 1`.
- Holding off the loser: a non-granted requester with `valid` high sees `ready = 1` and keeps waiting in its request state. It is never shown a falling `ready`, because a falling `ready` would signal acceptance.
- `rd_data`: `memory_bus.rd_data` is passed to both buses. It is meaningful only to the granted requester in its completion cycle.
- Writeback followed by a fill from the same cache is two separate arbitrations. A pending request from the other cache wins the second one, because round-robin favours the requester not granted last.

## Timing
- Reset values: `state = IDLE`, `grant = 0`, `last_grant = 0` (I), so D wins the first tie. Outputs: both `ready = 1`; `memory_bus.valid`, `write`, `addr`, `wr_data` all 0.
- Reset asserted in ISSUE or WAIT: return to IDLE on the next edge and drop `memory_bus.valid`. The in-flight memory transaction is abandoned; the caches are reset by the same signal.
- Latency:
  - Request `valid` is sampled in IDLE at cycle 0.
  - `memory_bus.valid` is high from cycle 1.
  - Requester `ready` falls in cycle 1.
  - Completion `ready` appears in the same cycle as `memory_bus.ready` rising in WAIT.
  - Arbiter overhead: 1 cycle per transaction.
- `memory_bus.ready == 0` in IDLE: no grant, and requests wait.
- A new `valid` arriving in the completion cycle is handled on the following IDLE cycle.
- Round-robin bounds waiting to one transaction from the other requester. No starvation.

## Test plan
- Lone I-cache fill, `addr = 0x0000_1000`, memory latency 5: `memory_bus.valid` high in cycle 1 only until memory `ready` drops. `icache_bus.ready` is 0 from cycle 1 and pulses 1 together with memory completion. `rd_data` equals the memory line. `dcache_bus.ready` stays 1 throughout.
- Simultaneous I fill (`0x100`) and D fill (`0x2000`) right after reset: D is granted first, then I. Memory sees `0x2000` then `0x100`. I sees `ready = 1` the whole time D is served.
- D writeback (`write = 1`, `0x3000`), then D fill (`0x4000`), with an I fill (`0x500`) pending: memory order is `0x3000` (write), `0x500`, `0x4000`. `memory_bus.write` follows the granted bus.
- Memory holds `ready = 1` for 3 cycles in ISSUE: `memory_bus.valid` stays 1 for those 3 cycles, and the granted `ready` stays 0.
- `reset_i` pulsed in WAIT: next cycle state is IDLE, both `ready = 1`, `memory_bus.valid = 0`. After reset, a fresh D request is granted D-first.
- Repeated contention over 8 requests: grants strictly alternate D, I, D, I, and so on.
